// File: rtl/stack_mem_pkg.sv
// Shared types and defaults for the stack/data memory stage.
package stack_mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        PUSH2,
        POP2,
        POPD
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_POP,
        REQ_PUSH,
        REQ_READ,
        REQ_WRITE
    } req_e;

    // Collapses simultaneous requests to the single winner: pop > push > read > write.
    function automatic req_e decode_req(input logic pop, input logic push,
                                        input logic rd, input logic wr);
        if (pop)       return REQ_POP;
        else if (push) return REQ_PUSH;
        else if (rd)   return REQ_READ;
        else if (wr)   return REQ_WRITE;
        else           return REQ_NONE;
    endfunction

endpackage

// File: rtl/stack_data_memory_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
interface stack_data_memory_if
    import stack_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                mem_read;
    logic                mem_write;
    logic                push;
    logic                pop;
    logic                wide;
    logic [ADDR_W-1:0]   address;
    logic [2*DATA_W-1:0] wdata;
    logic                err_clr;
    logic [2*DATA_W-1:0] rdata;
    logic                rdata_valid;
    logic                busy;
    logic [ADDR_W-1:0]   sp;
    logic                overflow;
    logic                underflow;

    modport master (
        output mem_read, mem_write, push, pop, wide, address, wdata, err_clr,
        input  rdata, rdata_valid, busy, sp, overflow, underflow
    );

    modport slave (
        input  mem_read, mem_write, push, pop, wide, address, wdata, err_clr,
        output rdata, rdata_valid, busy, sp, overflow, underflow
    );
endinterface

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered read port; contents are not reset.
module sp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write on enable; the read register only updates on a read so it holds otherwise.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/stack_data_memory.sv
// Data-memory stage: load/store plus a descending hardware stack with wide push/pop.
module stack_data_memory
    import stack_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_TOP   = (2**ADDR_W) - 1,
    parameter int STACK_LIMIT = (2**ADDR_W) / 2
) (
    input logic clk,
    input logic rst_n,
    stack_data_memory_if.slave bus
);
    localparam logic [ADDR_W:0] TopExt    = (ADDR_W+1)'(STACK_TOP);
    localparam logic [ADDR_W:0] LimitP1   = (ADDR_W+1)'(STACK_LIMIT + 1);
    localparam logic [ADDR_W:0] LimitP2   = (ADDR_W+1)'(STACK_LIMIT + 2);
    localparam logic [ADDR_W:0] OneExt    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TwoExt    = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] SpReset = ADDR_W'(STACK_TOP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [DATA_W-1:0]   low_q, low_d;
    logic                nvalid_q, nvalid_d;
    logic [2*DATA_W-1:0] rdata_q, rdata_d;

    logic [ADDR_W:0]     spExt;
    logic [ADDR_W-1:0]   spMinus1;
    logic [ADDR_W-1:0]   spPlus1;
    logic [ADDR_W-1:0]   ramAddr;
    logic                ramWe;
    logic                ramRe;
    logic [DATA_W-1:0]   ramWdata;
    logic [DATA_W-1:0]   ramRdata;
    logic                validOut;

    assign spExt    = {1'b0, sp_q};
    assign spMinus1 = sp_q - ADDR_W'(1);
    assign spPlus1  = sp_q + ADDR_W'(1);

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (ramAddr),
        .wdata_i (ramWdata),
        .rdata_o (ramRdata)
    );

    // State, pointer, flags and result holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sp_q     <= SpReset;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            low_q    <= '0;
            nvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            low_q    <= low_d;
            nvalid_q <= nvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state, RAM control and result selection; errors set after err_clr so the set wins.
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        ovf_d    = ovf_q & ~bus.err_clr;
        udf_d    = udf_q & ~bus.err_clr;
        low_d    = low_q;
        nvalid_d = 1'b0;
        ramAddr  = bus.address;
        ramWe    = 1'b0;
        ramRe    = 1'b0;
        ramWdata = bus.wdata[DATA_W-1:0];
        validOut = 1'b0;
        rdata_d  = rdata_q;

        if (nvalid_q) begin
            rdata_d  = {{DATA_W{1'b0}}, ramRdata};
            validOut = 1'b1;
        end else if (state_q == POPD) begin
            rdata_d  = {ramRdata, low_q};
            validOut = 1'b1;
        end

        case (state_q)
            IDLE: begin
                case (decode_req(bus.pop, bus.push, bus.mem_read, bus.mem_write))
                    REQ_POP: begin
                        if (bus.wide) begin
                            if (spExt + TwoExt > TopExt) udf_d = 1'b1;
                            else begin
                                ramRe   = 1'b1;
                                ramAddr = sp_q;
                                sp_d    = spPlus1;
                                state_d = POP2;
                            end
                        end else begin
                            if (spExt + OneExt > TopExt) udf_d = 1'b1;
                            else begin
                                ramRe    = 1'b1;
                                ramAddr  = sp_q;
                                sp_d     = spPlus1;
                                nvalid_d = 1'b1;
                            end
                        end
                    end
                    REQ_PUSH: begin
                        if (bus.wide) begin
                            if (spExt < LimitP2) ovf_d = 1'b1;
                            else begin
                                ramWe    = 1'b1;
                                ramAddr  = spMinus1;
                                ramWdata = bus.wdata[2*DATA_W-1:DATA_W];
                                sp_d     = spMinus1;
                                low_d    = bus.wdata[DATA_W-1:0];
                                state_d  = PUSH2;
                            end
                        end else begin
                            if (spExt < LimitP1) ovf_d = 1'b1;
                            else begin
                                ramWe   = 1'b1;
                                ramAddr = spMinus1;
                                sp_d    = spMinus1;
                            end
                        end
                    end
                    REQ_READ: begin
                        ramRe    = 1'b1;
                        nvalid_d = 1'b1;
                    end
                    REQ_WRITE: ramWe = 1'b1;
                    default: ;
                endcase
            end
            PUSH2: begin
                ramWe    = 1'b1;
                ramAddr  = spMinus1;
                ramWdata = low_q;
                sp_d     = spMinus1;
                state_d  = IDLE;
            end
            POP2: begin
                ramRe   = 1'b1;
                ramAddr = sp_q;
                low_d   = ramRdata;
                sp_d    = spPlus1;
                state_d = POPD;
            end
            POPD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.rdata       = rdata_d;
    assign bus.rdata_valid = validOut;
    assign bus.busy        = (state_q != IDLE);
    assign bus.sp          = sp_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;
endmodule
